sh_error_injector: RTL and testbench

- TX-side stimulus block that sits between the 64b/66b encoder/scrambler output and the lane distributor.
- Corrupts sync headers of 66-bit blocks at a programmed count per window, replacing them with invalid values 2'b00 or 2'b11.
- Drives the RX BER monitor into and out of hi-BER for link bring-up and self-test.
- Pass-through with one register stage when disabled.

---
 rtl/pcs_tx_pkg.sv | 20 ++
 rtl/sh_inj_window_timer.sv | 41 ++++
 rtl/sh_error_injector.sv | 199 +++++++++++++++++++
 tb/tb_sh_error_injector.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_tx_pkg.sv
`default_nettype none
// pcs_tx_pkg: shared PCS TX encodings (sync headers, injector modes, injector FSM states).
// Rev 1.0
package pcs_tx_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_SPREAD = 2'b10;
  localparam logic [1:0] MODE_RANDOM = 2'b11;

  localparam logic [3:0] IDLE   = 4'b0001;
  localparam logic [3:0] WAIT   = 4'b0010;
  localparam logic [3:0] INJECT = 4'b0100;
  localparam logic [3:0] HOLD   = 4'b1000;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sh_inj_window_timer.sv
`default_nettype none
// sh_inj_window_timer: counts valid blocks 0..XUS_WINDOW-1 and flags the last block of each window.
// Rev 1.0
module sh_inj_window_timer
  import pcs_tx_pkg::*;
#(
  parameter int XUS_WINDOW = 4096
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_valid,
  output logic o_win_end
);

  localparam int NB_TIMER = (XUS_WINDOW > 1) ? $clog2(XUS_WINDOW) : 1;
  localparam logic [NB_TIMER-1:0] LAST = NB_TIMER'(XUS_WINDOW - 1);

  logic [NB_TIMER-1:0] timer_q;
  logic [NB_TIMER-1:0] timer_d;
  logic                at_last;

  assign at_last   = (timer_q == LAST);
  assign o_win_end = i_valid && at_last;

  always_comb begin
    timer_d = timer_q;
    if (i_valid) begin
      timer_d = at_last ? '0 : timer_q + NB_TIMER'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sh_error_injector.sv
`default_nettype none
// sh_error_injector: corrupts 66b sync headers N times per window (burst/spread; random with SH_INJ_RANDOM_EN).
// Rev 1.0
module sh_error_injector
  import pcs_tx_pkg::*;
#(
  parameter int NB_DATA    = 64,
  parameter int NB_SH      = 2,
  parameter int XUS_WINDOW = 4096,
  parameter int NB_ERR_CNT = $clog2(XUS_WINDOW) + 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [NB_SH-1:0]      i_sh,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [NB_ERR_CNT-1:0] i_err_per_window,
  input  logic                  i_bad_sh_sel,
  output logic                  o_valid,
  output logic [NB_SH-1:0]      o_sh,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_inject_active,
  output logic [31:0]           o_err_total
);

  localparam int NB_ACC = NB_ERR_CNT + 1;
  localparam logic [NB_ERR_CNT-1:0] N_MAX   = NB_ERR_CNT'(XUS_WINDOW);
  localparam logic [NB_ACC-1:0]     ACC_WIN = NB_ACC'(XUS_WINDOW);

  logic                  valid_q;
  logic [NB_SH-1:0]      sh_q;
  logic [NB_DATA-1:0]    data_q;
  logic [3:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [NB_ERR_CNT-1:0] n_q, n_d;
  logic                  sel_q, sel_d;
  logic [NB_ERR_CNT-1:0] win_cnt_q, win_cnt_d;
  logic [NB_ACC-1:0]     acc_q, acc_d;
  logic [31:0]           err_total_q, err_total_d;

  logic                  win_end;
  logic                  mode_ok;
  logic                  run;
  logic                  load;
  logic                  hit;
  logic                  corrupt;
  logic [NB_ERR_CNT-1:0] n_clamped;
  logic [NB_ACC-1:0]     acc_sum;

  sh_inj_window_timer #(
    .XUS_WINDOW (XUS_WINDOW)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .o_win_end (win_end)
  );

`ifdef SH_INJ_RANDOM_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign mode_ok = (i_mode != MODE_OFF);

  // x^16+x^14+x^13+x^11+1, shifting right; advances once per valid block
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_valid) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign mode_ok = (i_mode == MODE_BURST) || (i_mode == MODE_SPREAD);
`endif

  assign run       = i_enable && mode_ok;
  assign n_clamped = (i_err_per_window > N_MAX) ? N_MAX : i_err_per_window;
  assign acc_sum   = acc_q + {1'b0, n_q};

  always_comb begin
    hit = 1'b0;
    case (mode_q)
      MODE_BURST:  hit = 1'b1;
      MODE_SPREAD: hit = (acc_sum >= ACC_WIN);
`ifdef SH_INJ_RANDOM_EN
      MODE_RANDOM: hit = (lfsr_q[NB_ERR_CNT-1:0] < n_q);
`endif
      default:     hit = 1'b0;
    endcase
  end

  // The per-window cap applies to every mode, so at most N headers are hit per window.
  assign corrupt = i_valid && run && (state_q == INJECT) && hit && (win_cnt_q < n_q);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (!run) begin
      state_d = IDLE;
    end else if (i_valid) begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          load    = 1'b1;
        end
        WAIT, HOLD, INJECT: begin
          if (win_end) begin
            load    = 1'b1;
            state_d = (n_clamped != '0) ? INJECT : WAIT;
          end else if ((state_q == INJECT) && (win_cnt_d == n_q)) begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    n_d    = n_q;
    sel_d  = sel_q;
    if (load) begin
      mode_d = i_mode;
      n_d    = n_clamped;
      sel_d  = i_bad_sh_sel;
    end
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (win_end) begin
      win_cnt_d = '0;
    end else if (corrupt) begin
      win_cnt_d = win_cnt_q + NB_ERR_CNT'(1);
    end
  end

  // Bresenham accumulator: only meaningful while injecting, cleared on every window boundary.
  always_comb begin
    acc_d = acc_q;
    if (win_end) begin
      acc_d = '0;
    end else if (i_valid && run && (state_q == INJECT)) begin
      acc_d = (acc_sum >= ACC_WIN) ? acc_sum - ACC_WIN : acc_sum;
    end
  end

  always_comb begin
    err_total_d = err_total_q;
    if (corrupt && (err_total_q != 32'hFFFF_FFFF)) begin
      err_total_d = err_total_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      valid_q     <= 1'b0;
      sh_q        <= '0;
      data_q      <= '0;
      state_q     <= IDLE;
      mode_q      <= MODE_OFF;
      n_q         <= '0;
      sel_q       <= 1'b0;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      err_total_q <= '0;
    end else begin
      valid_q     <= i_valid;
      sh_q        <= corrupt ? {NB_SH{sel_q}} : i_sh;
      data_q      <= i_data;
      state_q     <= state_d;
      mode_q      <= mode_d;
      n_q         <= n_d;
      sel_q       <= sel_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      err_total_q <= err_total_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_sh            = sh_q;
  assign o_data          = data_q;
  assign o_inject_active = (state_q == INJECT) || (state_q == HOLD);
  assign o_err_total     = err_total_q;

endmodule
`default_nettype wire

// File: tb/tb_sh_error_injector.sv
`default_nettype none
// tb_sh_error_injector: scoreboard bench for sh_error_injector, directed phases with hand-derived corruption maps.
// Rev 1.0
module tb_sh_error_injector;
  import pcs_tx_pkg::*;

  localparam int W = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid;
  logic [1:0]  sh;
  logic [63:0] data;
  logic        en;
  logic [1:0]  mode;
  logic [12:0] nerr;
  logic        sel;

  logic        dut_valid;
  logic [1:0]  dut_sh;
  logic [63:0] dut_data;
  logic        dut_active;
  logic [31:0] dut_total;

  sh_error_injector #(
    .NB_DATA    (64),
    .NB_SH      (2),
    .XUS_WINDOW (W),
    .NB_ERR_CNT (13)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_valid          (valid),
    .i_sh             (sh),
    .i_data           (data),
    .i_enable         (en),
    .i_mode           (mode),
    .i_err_per_window (nerr),
    .i_bad_sh_sel     (sel),
    .o_valid          (dut_valid),
    .o_sh             (dut_sh),
    .o_data           (dut_data),
    .o_inject_active  (dut_active),
    .o_err_total      (dut_total)
  );

  typedef struct packed {
    logic [1:0]  sh;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          blk = 0;
  int          vb;
  logic        nxt_en;
  logic [12:0] nxt_n;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dut_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got o_valid=1 sh=%b, expected no block", dut_sh);
        end else begin
          e = sb.pop_front();
          if ((dut_sh !== e.sh) || (dut_data !== e.data)) begin
            errors++;
            $display("FAIL block: got sh=%b data=%h, expected sh=%b data=%h",
                     dut_sh, dut_data, e.sh, e.data);
          end
        end
      end
    end
  endtask

  // One cycle: config follows the block so a change lands on exactly that block.
  task automatic drive(input logic v, input logic corrupt);
    exp_t e;
    @(posedge clk);
    #1;
    en    = nxt_en;
    nerr  = nxt_n;
    valid = v;
    sh    = blk[0] ? SH_CTRL : SH_DATA;
    data  = {32'(blk), ~32'(blk)};
    if (v) begin
      e.sh   = corrupt ? {2{sel}} : sh;
      e.data = data;
      sb.push_back(e);
    end
    blk++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic v_inflight);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = v_inflight;
    sh    = SH_CTRL;
    data  = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = 1'b0;
    chk("rst_valid",  64'(dut_valid),  64'd0);
    chk("rst_sh",     64'(dut_sh),     64'd0);
    chk("rst_data",   dut_data,        64'd0);
    chk("rst_total",  64'(dut_total),  64'd0);
    chk("rst_active", 64'(dut_active), 64'd0);
  endtask

  task automatic set_cfg(input logic e, input logic [1:0] m, input logic [12:0] n, input logic s);
    nxt_en = e;
    nxt_n  = n;
    mode   = m;
    sel    = s;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; sh = '0; data = '0;
    en = 1'b0; mode = MODE_OFF; nerr = '0; sel = 1'b0;
    nxt_en = 1'b0; nxt_n = '0;
    fork
      monitor();
    join_none

    // Disabled pass-through
    set_cfg(1'b0, MODE_BURST, 13'd970, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 10000; i++) drive(1'b1, 1'b0);
    idle(2);
    chk("pass_total",  64'(dut_total),  64'd0);
    chk("pass_active", 64'(dut_active), 64'd0);

    // Burst: one alignment window, then two injecting windows
    set_cfg(1'b1, MODE_BURST, 13'd970, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 3 * W; i++) drive(1'b1, (i >= W) && ((i % W) < 970));
    idle(2);
    chk("burst_total",  64'(dut_total),  64'd1940);
    chk("burst_active", 64'(dut_active), 64'd1);

    // Spread: N=4 lands on indices 1023/2047/3071/4095
    set_cfg(1'b1, MODE_SPREAD, 13'd4, 1'b1);
    do_reset(1'b0);
    for (int i = 0; i < 2 * W; i++)
      drive(1'b1, (i >= W) && (((i % W) + 1) % 1024 == 0));
    idle(2);
    chk("spread_total",  64'(dut_total),  64'd4);
    chk("spread_active", 64'(dut_active), 64'd1);

    // Mid-window disable with a gap on every third cycle
    set_cfg(1'b1, MODE_BURST, 13'd100, 1'b0);
    do_reset(1'b0);
    vb = 0;
    for (int c = 0; vb < W + 200; c++) begin
      nxt_en = (vb < W + 50);
      if (c % 3 == 2) begin
        drive(1'b0, 1'b0);
      end else begin
        drive(1'b1, (vb >= W) && (vb < W + 50));
        vb++;
      end
    end
    idle(2);
    chk("gap_total",  64'(dut_total),  64'd50);
    chk("gap_active", 64'(dut_active), 64'd0);

    // Clamp 5000 -> 4096, then N=0 latched at the end of the corrupted window
    set_cfg(1'b1, MODE_BURST, 13'd5000, 1'b1);
    do_reset(1'b0);
    for (int i = 0; i < 2 * W + 100; i++) begin
      nxt_n = (i < W) ? 13'd5000 : 13'd0;
      drive(1'b1, (i >= W) && (i < 2 * W));
    end
    idle(2);
    chk("clamp_total",  64'(dut_total),  64'd4096);
    chk("clamp_active", 64'(dut_active), 64'd0);

    // Reset in the middle of an injecting window, then realign
    set_cfg(1'b1, MODE_BURST, 13'd500, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < W + 300; i++) drive(1'b1, (i >= W) && ((i % W) < 500));
    idle(2);
    chk("pre_rst_total",  64'(dut_total),  64'd300);
    chk("pre_rst_active", 64'(dut_active), 64'd1);
    do_reset(1'b1);
    for (int i = 0; i < W + 600; i++) drive(1'b1, (i >= W) && ((i - W) < 500));
    idle(2);
    chk("post_rst_total",  64'(dut_total),  64'd500);
    chk("post_rst_active", 64'(dut_active), 64'd1);

    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
